// File: rtl/mmc_chan_rd_seq.sv
// Per-channel MMC read sequencer: accepts line-read requests, tracks open pages
// per bank, issues close/open/read commands toward dfi honouring tRP/tRCD, and
// frames returned beats into tagged responses using an in-order tag FIFO.
module mmc_chan_rd_seq #(
    parameter  int NUM_BANKS = 32,
    parameter  int ADDR_W    = 12,
    parameter  int DATA_W    = 512,
    parameter  int TAG_W     = 4,
    parameter  int T_RCD     = 4,
    parameter  int T_RP      = 3,
    parameter  int BURST_LEN = 2,
    parameter  int MAX_OUTST = 4,
    localparam int BANK_W    = $clog2(NUM_BANKS)
) (
    input  logic              clk,
    input  logic              reset_poweron,
    input  logic              dfi__mmc__init_done,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [BANK_W-1:0] req_bank,
    input  logic [ADDR_W-1:0] req_page,
    input  logic [ADDR_W-1:0] req_line,
    input  logic [TAG_W-1:0]  req_tag,
    output logic              mmc__dfi__cs,
    output logic              mmc__dfi__cmd1,
    output logic              mmc__dfi__cmd0,
    output logic [BANK_W-1:0] mmc__dfi__bank,
    output logic [ADDR_W-1:0] mmc__dfi__addr,
    input  logic              dfi__mmc__valid,
    input  logic [1:0]        dfi__mmc__cntl,
    input  logic [DATA_W-1:0] dfi__mmc__data,
    output logic              rsp_valid,
    output logic [1:0]        rsp_cntl,
    output logic [TAG_W-1:0]  rsp_tag,
    output logic [DATA_W-1:0] rsp_data,
    output logic              err_unexp_rsp
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_CLOSE    = 3'd1;
    localparam logic [2:0] S_WAIT_RP  = 3'd2;
    localparam logic [2:0] S_OPEN     = 3'd3;
    localparam logic [2:0] S_WAIT_RCD = 3'd4;
    localparam logic [2:0] S_HIT      = 3'd5;

    localparam logic [1:0] CMD_OPEN  = 2'b00;
    localparam logic [1:0] CMD_READ  = 2'b01;
    localparam logic [1:0] CMD_CLOSE = 2'b11;

    // cntl encoding: SOM=10, MOM=00, EOM=01, single-beat=11; bit 0 marks the last beat
    localparam int EOM_BIT = 0;

    localparam int TMAX   = (T_RCD > T_RP) ? T_RCD : T_RP;
    localparam int TMR_W  = (TMAX > 1) ? $clog2(TMAX + 1) : 1;
    localparam int PTR_W  = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int CNT_W  = $clog2(MAX_OUTST + 1);
    localparam int BCNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN + 1) : 1;

    logic [2:0]        state;
    logic [TMR_W-1:0]  timer;
    logic [BANK_W-1:0] cur_bank;
    logic [ADDR_W-1:0] cur_page;
    logic [ADDR_W-1:0] cur_line;
    logic [TAG_W-1:0]  cur_tag;

    logic [NUM_BANKS-1:0] bank_open;
    logic [ADDR_W-1:0]    bank_page [NUM_BANKS];

    logic [TAG_W-1:0]  tag_fifo [MAX_OUTST];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  outst;
    logic [BCNT_W-1:0] beat_cnt;

    logic accept;
    logic do_close;
    logic do_open;
    logic do_read;
    logic push;
    logic pop;
    logic beat_ok;
    logic beat_last;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OUTST - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign req_ready = !reset_poweron && (state == S_IDLE) && dfi__mmc__init_done &&
                       (outst < CNT_W'(MAX_OUTST));
    assign accept    = req_valid && req_ready;

    // Commands only leave while the phy reports init done; otherwise the FSM holds.
    assign do_close = (state == S_CLOSE) && dfi__mmc__init_done;
    assign do_open  = (state == S_OPEN)  && dfi__mmc__init_done;
    assign do_read  = (state == S_HIT)   && dfi__mmc__init_done;
    assign push     = do_read;

    // A beat with nothing outstanding has no tag to attach and is dropped.
    // The last beat is the EOM-marked one; a burst of BURST_LEN beats also closes a read
    // so a lost EOM cannot wedge the tag FIFO.
    assign beat_ok   = dfi__mmc__valid && (outst != '0);
    assign beat_last = dfi__mmc__cntl[EOM_BIT] || (beat_cnt == BCNT_W'(BURST_LEN - 1));
    assign pop       = beat_ok && beat_last;

    // Sequencer FSM, bank open flags and tRP/tRCD timer.
    always_ff @(posedge clk) begin
        if (reset_poweron) begin
            state     <= S_IDLE;
            timer     <= '0;
            bank_open <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (bank_open[req_bank] && (bank_page[req_bank] == req_page))
                            state <= S_HIT;
                        else if (bank_open[req_bank])
                            state <= S_CLOSE;
                        else
                            state <= S_OPEN;
                    end
                end
                S_CLOSE: begin
                    if (do_close) begin
                        bank_open[cur_bank] <= 1'b0;
                        timer               <= TMR_W'(T_RP - 1);
                        state               <= S_WAIT_RP;
                    end
                end
                S_WAIT_RP: begin
                    if (timer == '0) state <= S_OPEN;
                    else             timer <= timer - TMR_W'(1);
                end
                S_OPEN: begin
                    if (do_open) begin
                        bank_open[cur_bank] <= 1'b1;
                        timer               <= TMR_W'(T_RCD - 1);
                        state               <= S_WAIT_RCD;
                    end
                end
                S_WAIT_RCD: begin
                    if (timer == '0) state <= S_HIT;
                    else             timer <= timer - TMR_W'(1);
                end
                S_HIT: begin
                    if (do_read) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Request latch, per-bank page store and tag FIFO storage (data only, no reset).
    always_ff @(posedge clk) begin
        if (accept) begin
            cur_bank <= req_bank;
            cur_page <= req_page;
            cur_line <= req_line;
            cur_tag  <= req_tag;
        end
        if (do_open)
            bank_page[cur_bank] <= cur_page;
        if (push)
            tag_fifo[wr_ptr] <= cur_tag;
    end

    // Registered command bus; everything is zero on cycles with no command.
    always_ff @(posedge clk) begin
        if (reset_poweron) begin
            mmc__dfi__cs   <= 1'b0;
            mmc__dfi__cmd1 <= 1'b0;
            mmc__dfi__cmd0 <= 1'b0;
            mmc__dfi__bank <= '0;
            mmc__dfi__addr <= '0;
        end else begin
            mmc__dfi__cs   <= 1'b0;
            mmc__dfi__cmd1 <= 1'b0;
            mmc__dfi__cmd0 <= 1'b0;
            mmc__dfi__bank <= '0;
            mmc__dfi__addr <= '0;
            if (do_close) begin
                mmc__dfi__cs                     <= 1'b1;
                {mmc__dfi__cmd1, mmc__dfi__cmd0} <= CMD_CLOSE;
                mmc__dfi__bank                   <= cur_bank;
            end else if (do_open) begin
                mmc__dfi__cs                     <= 1'b1;
                {mmc__dfi__cmd1, mmc__dfi__cmd0} <= CMD_OPEN;
                mmc__dfi__bank                   <= cur_bank;
                mmc__dfi__addr                   <= cur_page;
            end else if (do_read) begin
                mmc__dfi__cs                     <= 1'b1;
                {mmc__dfi__cmd1, mmc__dfi__cmd0} <= CMD_READ;
                mmc__dfi__bank                   <= cur_bank;
                mmc__dfi__addr                   <= cur_line;
            end
        end
    end

    // Tag FIFO pointers, outstanding-read count and per-read beat counter.
    always_ff @(posedge clk) begin
        if (reset_poweron) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            outst    <= '0;
            beat_cnt <= '0;
        end else begin
            if (push) wr_ptr <= ptr_next(wr_ptr);
            if (pop)  rd_ptr <= ptr_next(rd_ptr);
            if (pop)          beat_cnt <= '0;
            else if (beat_ok) beat_cnt <= beat_cnt + BCNT_W'(1);
            case ({push, pop})
                2'b10:   outst <= outst + CNT_W'(1);
                2'b01:   outst <= outst - CNT_W'(1);
                default: outst <= outst;
            endcase
        end
    end

    // Return path: one register stage, tagged with the FIFO head; sticky unexpected-beat flag.
    always_ff @(posedge clk) begin
        if (reset_poweron) begin
            rsp_valid     <= 1'b0;
            rsp_cntl      <= '0;
            rsp_tag       <= '0;
            rsp_data      <= '0;
            err_unexp_rsp <= 1'b0;
        end else begin
            rsp_valid <= beat_ok;
            if (beat_ok) begin
                rsp_cntl <= dfi__mmc__cntl;
                rsp_tag  <= tag_fifo[rd_ptr];
                rsp_data <= dfi__mmc__data;
            end
            if (dfi__mmc__valid && (outst == '0))
                err_unexp_rsp <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mmc_chan_rd_seq.sv
// Directed bench for mmc_chan_rd_seq: command timing for hit/closed/conflict,
// outstanding cap, tagged return framing, unexpected beats and mid-op reset.
module tb_mmc_chan_rd_seq;

    localparam logic [1:0] SOM = 2'b10;
    localparam logic [1:0] EOM = 2'b01;
    localparam logic [1:0] C_OPEN  = 2'b00;
    localparam logic [1:0] C_READ  = 2'b01;
    localparam logic [1:0] C_CLOSE = 2'b11;

    logic         clk;
    logic         rst;
    logic         init_done;
    logic         req_valid;
    logic         req_ready;
    logic [4:0]   req_bank;
    logic [11:0]  req_page;
    logic [11:0]  req_line;
    logic [3:0]   req_tag;
    logic         cs;
    logic         cmd1;
    logic         cmd0;
    logic [4:0]   cbank;
    logic [11:0]  caddr;
    logic         dv;
    logic [1:0]   dcntl;
    logic [511:0] ddata;
    logic         rsp_valid;
    logic [1:0]   rsp_cntl;
    logic [3:0]   rsp_tag;
    logic [511:0] rsp_data;
    logic         err;

    int total = 0;
    int bad   = 0;

    mmc_chan_rd_seq dut (
        .clk                 (clk),
        .reset_poweron       (rst),
        .dfi__mmc__init_done (init_done),
        .req_valid           (req_valid),
        .req_ready           (req_ready),
        .req_bank            (req_bank),
        .req_page            (req_page),
        .req_line            (req_line),
        .req_tag             (req_tag),
        .mmc__dfi__cs        (cs),
        .mmc__dfi__cmd1      (cmd1),
        .mmc__dfi__cmd0      (cmd0),
        .mmc__dfi__bank      (cbank),
        .mmc__dfi__addr      (caddr),
        .dfi__mmc__valid     (dv),
        .dfi__mmc__cntl      (dcntl),
        .dfi__mmc__data      (ddata),
        .rsp_valid           (rsp_valid),
        .rsp_cntl            (rsp_cntl),
        .rsp_tag             (rsp_tag),
        .rsp_data            (rsp_data),
        .err_unexp_rsp       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        check(tag, 512'(obs), 512'(exp));
    endtask

    function automatic logic [19:0] cmdv(input logic c, input logic [1:0] code,
                                         input logic [4:0] b, input logic [11:0] a);
        return {c, code, b, a};
    endfunction

    task automatic expect_cmd(input string tag, input logic [19:0] exp);
        logic [19:0] act;
        act = {cs, cmd1, cmd0, cbank, caddr};
        check(tag, 512'(act), 512'(exp));
    endtask

    task automatic idle_cycles(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            tick();
            expect_cmd(tag, 20'd0);
        end
    endtask

    task automatic send_req(input logic [4:0] b, input logic [11:0] p,
                            input logic [11:0] l, input logic [3:0] t);
        int n;
        n = 0;
        req_bank  = b;
        req_page  = p;
        req_line  = l;
        req_tag   = t;
        req_valid = 1'b1;
        while (!req_ready && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) chk1("req_accept_timeout", req_ready, 1'b1);
        tick();
        req_valid = 1'b0;
    endtask

    task automatic beat(input logic [1:0] c, input logic [511:0] d);
        dv    = 1'b1;
        dcntl = c;
        ddata = d;
        tick();
        dv    = 1'b0;
        dcntl = 2'b00;
    endtask

    task automatic ret_read(input logic [3:0] t, input logic [31:0] w);
        logic [511:0] d;
        d = {16{w}};
        beat(SOM, d);
        chk1("ret_som_valid", rsp_valid, 1'b1);
        check("ret_som_tag", 512'(rsp_tag), 512'(t));
        check("ret_som_cntl", 512'(rsp_cntl), 512'(SOM));
        check("ret_som_data", rsp_data, d);
        d = ~d;
        beat(EOM, d);
        chk1("ret_eom_valid", rsp_valid, 1'b1);
        check("ret_eom_tag", 512'(rsp_tag), 512'(t));
        check("ret_eom_cntl", 512'(rsp_cntl), 512'(EOM));
        check("ret_eom_data", rsp_data, d);
    endtask

    initial begin
        rst       = 1'b1;
        init_done = 1'b0;
        req_valid = 1'b0;
        req_bank  = '0;
        req_page  = '0;
        req_line  = '0;
        req_tag   = '0;
        dv        = 1'b0;
        dcntl     = 2'b00;
        ddata     = '0;

        // reset state
        tick(); tick(); tick();
        expect_cmd("rst_cmd", 20'd0);
        chk1("rst_ready", req_ready, 1'b0);
        chk1("rst_rsp_valid", rsp_valid, 1'b0);
        chk1("rst_err", err, 1'b0);
        rst = 1'b0;
        tick();

        // no acceptance and no commands before init done
        chk1("noinit_ready", req_ready, 1'b0);
        req_valid = 1'b1;
        req_bank  = 5'd1;
        tick(); tick();
        expect_cmd("noinit_cmd", 20'd0);
        req_valid = 1'b0;
        init_done = 1'b1;
        #1;
        chk1("init_ready", req_ready, 1'b1);

        // T1: closed bank -> open N+1, read N+2+T_RCD
        send_req(5'd3, 12'h012, 12'd5, 4'd1);
        tick();
        expect_cmd("t1_open", cmdv(1'b1, C_OPEN, 5'd3, 12'h012));
        chk1("t1_busy", req_ready, 1'b0);
        idle_cycles(4, "t1_rcd_gap");
        tick();
        expect_cmd("t1_read", cmdv(1'b1, C_READ, 5'd3, 12'd5));
        chk1("t1_ready", req_ready, 1'b1);

        // T2: page hit -> read N+1
        send_req(5'd3, 12'h012, 12'd6, 4'd2);
        tick();
        expect_cmd("t2_read", cmdv(1'b1, C_READ, 5'd3, 12'd6));
        idle_cycles(2, "t2_quiet");

        // T3: page conflict -> close N+1, open N+5, read N+10
        send_req(5'd3, 12'h040, 12'd7, 4'd3);
        tick();
        expect_cmd("t3_close", cmdv(1'b1, C_CLOSE, 5'd3, 12'd0));
        idle_cycles(3, "t3_rp_gap");
        tick();
        expect_cmd("t3_open", cmdv(1'b1, C_OPEN, 5'd3, 12'h040));
        idle_cycles(4, "t3_rcd_gap");
        tick();
        expect_cmd("t3_read", cmdv(1'b1, C_READ, 5'd3, 12'd7));

        // returns for tags 1..3 in order
        ret_read(4'd1, 32'h1111_0001);
        ret_read(4'd2, 32'h2222_0002);
        ret_read(4'd3, 32'h3333_0003);
        tick();
        chk1("rsp_idle", rsp_valid, 1'b0);

        // T4: four hits fill the outstanding cap
        for (int i = 0; i < 4; i++) begin
            send_req(5'd3, 12'h040, 12'(8 + i), 4'(4 + i));
            tick();
            expect_cmd("t4_read", cmdv(1'b1, C_READ, 5'd3, 12'(8 + i)));
        end
        chk1("t4_full", req_ready, 1'b0);
        tick();
        chk1("t4_full_hold", req_ready, 1'b0);
        ret_read(4'd4, 32'h4444_0004);
        chk1("t4_ready_back", req_ready, 1'b1);

        // push (read issue) and pop (EOM) on the same edge
        beat(SOM, {16{32'h5555_0005}});
        check("pp_som_tag", 512'(rsp_tag), 512'(4'd5));
        send_req(5'd3, 12'h040, 12'd12, 4'd8);
        dv    = 1'b1;
        dcntl = EOM;
        ddata = {16{32'hAAAA_5555}};
        tick();
        dv    = 1'b0;
        dcntl = 2'b00;
        expect_cmd("pp_read", cmdv(1'b1, C_READ, 5'd3, 12'd12));
        check("pp_eom_tag", 512'(rsp_tag), 512'(4'd5));
        check("pp_eom_cntl", 512'(rsp_cntl), 512'(EOM));
        ret_read(4'd6, 32'h6666_0006);
        ret_read(4'd7, 32'h7777_0007);
        ret_read(4'd8, 32'h8888_0008);

        // T5: beat with nothing outstanding is dropped and flags a sticky error
        beat(SOM, {16{32'hDEAD_BEEF}});
        chk1("t5_drop", rsp_valid, 1'b0);
        chk1("t5_err", err, 1'b1);
        tick(); tick();
        chk1("t5_err_sticky", err, 1'b1);

        // reset during WAIT_RCD abandons the read and closes all banks
        send_req(5'd9, 12'h021, 12'd1, 4'd9);
        tick();
        expect_cmd("t5_open", cmdv(1'b1, C_OPEN, 5'd9, 12'h021));
        tick();
        rst = 1'b1;
        tick();
        expect_cmd("t5_rst_cmd", 20'd0);
        chk1("t5_rst_err", err, 1'b0);
        chk1("t5_rst_ready", req_ready, 1'b0);
        rst = 1'b0;
        idle_cycles(6, "t5_abandon");
        send_req(5'd3, 12'h040, 12'd2, 4'd10);
        tick();
        expect_cmd("t5_b3_closed", cmdv(1'b1, C_OPEN, 5'd3, 12'h040));
        idle_cycles(4, "t5_rcd_gap");
        tick();
        expect_cmd("t5_b3_read", cmdv(1'b1, C_READ, 5'd3, 12'd2));
        ret_read(4'd10, 32'hA0A0_000A);
        chk1("t5_final_ready", req_ready, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
